// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: read-miss line refill and write-through store controller.
// On a load miss the 4-word line is fetched from memory word by word and
// written into the cache with a single fill strobe. Stores are forwarded to
// memory and the pipeline is held until memory acknowledges.
module cache_refill_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  req_byte,
    input  logic                  hit,
    output logic                  stall,
    output logic                  mem_req,
    output logic [DATA_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rvalid,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wbyte,
    input  logic                  mem_wack,
    output logic                  fill_en,
    output logic [DATA_WIDTH-1:0] fill_addr,
    output logic [DATA_WIDTH-1:0] fill_d0,
    output logic [DATA_WIDTH-1:0] fill_d1,
    output logic [DATA_WIDTH-1:0] fill_d2,
    output logic [DATA_WIDTH-1:0] fill_d3,
    output logic [31:0]           miss_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_FILL  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    // Line base clears the 16-byte offset of the request address.
    localparam logic [DATA_WIDTH-1:0] LINE_MASK = ~DATA_WIDTH'(15);

    state_t                state_q, state_d;
    logic [1:0]            word_cnt_q, word_cnt_d;
    logic [DATA_WIDTH-1:0] line_base_q, line_base_d;
    logic [DATA_WIDTH-1:0] line_buf_q [0:3];
    logic [DATA_WIDTH-1:0] line_buf_d [0:3];
    logic [DATA_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  wr_byte_q, wr_byte_d;
    logic [31:0]           miss_count_q, miss_count_d;

    logic                  load_miss_s;
    logic                  store_s;

    assign load_miss_s = req_valid & ~req_we & ~hit;
    assign store_s     = req_valid & req_we;

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; request inputs only matter in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (store_s) begin
                    state_d = S_WRITE;
                end else if (load_miss_s) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                if (mem_rvalid && (word_cnt_q == 2'd3)) begin
                    state_d = S_FILL;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_FILL: begin
                state_d = S_IDLE;
            end
            S_WRITE: begin
                if (mem_wack) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WRITE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath next values: request latching, word capture, miss counting.
    always_comb begin
        word_cnt_d   = word_cnt_q;
        line_base_d  = line_base_q;
        line_buf_d   = line_buf_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        wr_byte_d    = wr_byte_q;
        miss_count_d = miss_count_q;
        case (state_q)
            S_IDLE: begin
                if (store_s) begin
                    wr_addr_d = req_addr;
                    wr_data_d = req_wdata;
                    wr_byte_d = req_byte;
                end else if (load_miss_s) begin
                    line_base_d = req_addr & LINE_MASK;
                    word_cnt_d  = 2'd0;
                    if (miss_count_q != 32'hFFFF_FFFF) begin
                        miss_count_d = miss_count_q + 32'd1;
                    end else begin
                        miss_count_d = miss_count_q;
                    end
                end else begin
                    word_cnt_d = word_cnt_q;
                end
            end
            S_FETCH: begin
                if (mem_rvalid) begin
                    line_buf_d[word_cnt_q] = mem_rdata;
                    word_cnt_d             = word_cnt_q + 2'd1;
                end else begin
                    word_cnt_d = word_cnt_q;
                end
            end
            S_FILL: begin
                word_cnt_d = word_cnt_q;
            end
            S_WRITE: begin
                word_cnt_d = word_cnt_q;
            end
            default: begin
                word_cnt_d = 2'd0;
            end
        endcase
    end

    // Datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt_q   <= 2'd0;
            line_base_q  <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_byte_q    <= 1'b0;
            miss_count_q <= 32'd0;
            for (int i = 0; i < 4; i++) begin
                line_buf_q[i] <= '0;
            end
        end else begin
            word_cnt_q   <= word_cnt_d;
            line_base_q  <= line_base_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_byte_q    <= wr_byte_d;
            miss_count_q <= miss_count_d;
            for (int i = 0; i < 4; i++) begin
                line_buf_q[i] <= line_buf_d[i];
            end
        end
    end

    // Output decode; everything is forced quiet while reset is asserted so an
    // interrupted fetch or store emits nothing further.
    always_comb begin
        stall     = 1'b0;
        mem_req   = 1'b0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        mem_wbyte = 1'b0;
        fill_en   = 1'b0;
        fill_addr = '0;
        fill_d0   = '0;
        fill_d1   = '0;
        fill_d2   = '0;
        fill_d3   = '0;
        if (rst) begin
            stall = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    stall = load_miss_s | store_s;
                end
                S_FETCH: begin
                    stall    = 1'b1;
                    mem_req  = 1'b1;
                    mem_addr = line_base_q + DATA_WIDTH'({word_cnt_q, 2'b00});
                end
                S_FILL: begin
                    stall     = 1'b1;
                    fill_en   = 1'b1;
                    fill_addr = line_base_q;
                    fill_d0   = line_buf_q[0];
                    fill_d1   = line_buf_q[1];
                    fill_d2   = line_buf_q[2];
                    fill_d3   = line_buf_q[3];
                end
                S_WRITE: begin
                    // Release in the acknowledge cycle so the store is not reissued.
                    stall     = ~mem_wack;
                    mem_we    = 1'b1;
                    mem_addr  = wr_addr_q;
                    mem_wdata = wr_data_q;
                    mem_wbyte = wr_byte_q;
                end
                default: begin
                    stall = 1'b0;
                end
            endcase
        end
    end

    assign miss_count = miss_count_q;

endmodule

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Miss-handling and write-through controller between the memory-stage request port and the data cache / main data memory pair. On a read miss it stalls the pipeline, fetches the 4-word line from memory one word at a time, and then writes the whole line into the cache through a one-cycle fill strobe. On a store it forwards the write to memory and holds the stall until memory acknowledges. It holds no cache data itself; hit detection stays in the cache.

## Interface
Parameters:
- DATA_WIDTH, 32, address and data width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  memory stage presents a load or store this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  DATA_WIDTH  byte address of the request.
- req_wdata  in  DATA_WIDTH  store data.
- req_byte  in  1  byte-sized access; passed through on stores.
- hit  in  1  combinational cache hit for req_addr.
- stall  out  1  freeze the pipeline; the request is held stable while high.
- mem_req  out  1  word read request to memory.
- mem_addr  out  DATA_WIDTH  address for mem_req or mem_we.
- mem_rdata  in  DATA_WIDTH  returned read word.
- mem_rvalid  in  1  mem_rdata is valid this cycle.
- mem_we  out  1  store request to memory.
- mem_wdata  out  DATA_WIDTH  store data.
- mem_wbyte  out  1  byte store.
- mem_wack  in  1  memory accepted the store this cycle.
- fill_en  out  1  one-cycle strobe that writes the line into the cache.
- fill_addr  out  DATA_WIDTH  line base address, with bits [3:0] = 0.
- fill_d0..fill_d3  out  DATA_WIDTH each  line words at offsets 0x0, 0x4, 0x8 and 0xC.
- miss_count  out  32  count of read misses; saturates at 0xFFFFFFFF.

## Operation
States are IDLE, FETCH, FILL and WRITE.

IDLE:
- req_valid & !req_we & hit: no action, stall = 0.
- req_valid & !req_we & !hit:
  - Latch line_base = {req_addr[31:4], 4'b0}.
  - Clear word_cnt.
  - Increment miss_count (saturating).
  - Go to FETCH. stall = 1.
- req_valid & req_we:
  - Latch the address, data and byte flag.
  - Go to WRITE. stall = 1.
  - Stores never allocate. Keeping a hitting line coherent is the cache's job on the same request.
- !req_valid: stall = 0.

FETCH:
- mem_req = 1 and mem_addr = line_base + 4·word_cnt.
- On mem_rvalid:
  - buf[word_cnt] ← mem_rdata.
  - word_cnt increments (2 bits).
  - If word_cnt was 3, go to FILL.
- stall = 1.

FILL:
- fill_en = 1, fill_addr = line_base, fill_d0..d3 = buf[0..3]. stall = 1.
- Next state is IDLE.
- The held request then hits, so stall drops and the load completes.

WRITE:
- mem_we = 1, with mem_addr, mem_wdata and mem_wbyte taken from the latched values.
- stall = !mem_wack. On mem_wack, go to IDLE.
- This lets the pipeline advance in the acknowledge cycle, so the store is not reissued.

Boundary rules:
- mem_rvalid outside FETCH is ignored.
- mem_wack outside WRITE is ignored.
- Request inputs are not sampled outside IDLE.
- When miss_count is 0xFFFFFFFF, a further miss leaves it unchanged.

## Timing
- Reset state (in effect from the cycle after rst is sampled high):
  - state = IDLE, word_cnt = 0, buf = 0, latched address/data = 0, miss_count = 0.
  - While reset is asserted: stall, mem_req, mem_we and fill_en = 0, and mem_addr, fill_addr and fill_d* = 0.
- Reset asserted during FETCH, FILL or WRITE aborts the operation. No fill_en and no further mem_req or mem_we are produced.
- stall is combinational from state, req_valid, req_we, hit and mem_wack. All other outputs are decoded from registered state only.
- Read hit: 0 stall cycles.
- Read miss with mem_rvalid returned in the same cycle as each mem_req:
  - 1 IDLE cycle + 4 FETCH cycles + 1 FILL cycle = 6 stalled cycles.
  - The load completes in the 7th cycle.
  - Each memory-side gap cycle adds one stalled cycle.
- Store with mem_wack in the first WRITE cycle: 1 stalled cycle. The pipeline advances at the end of the WRITE cycle.
- fill_en is high for exactly one cycle per completed miss.

## Test plan
- Reset: hold rst for 2 cycles during random inputs, then release. Required: stall, mem_req, mem_we and fill_en = 0 and miss_count = 0.
- Read hit: req_valid = 1, req_we = 0, hit = 1, addr 0x40. Required: stall = 0 and mem_req never asserted.
- Read miss with back-to-back data:
  - Stimulus: addr 0x1234, hit = 0, memory returns 0xA0, 0xA1, 0xA2, 0xA3 with rvalid in the same cycle as each request.
  - Required: mem_addr sequence 0x1230, 0x1234, 0x1238, 0x123C.
  - Required: one fill_en with fill_addr 0x1230 and d0..d3 = 0xA0..0xA3. stall is high for 6 cycles. miss_count = 1.
- Miss with gaps: the same stimulus, but rvalid arrives every third cycle. Required: buffer order is correct and stall is extended by exactly the gap cycles.
- Store: addr 0x80, data 0xDEADBEEF, req_byte = 1, with mem_wack delayed 2 cycles.
  - Required: mem_we held for 3 cycles with stable address and data.
  - Required: stall drops in the acknowledge cycle, exactly one write occurs, and no fill occurs.
- Reset mid-FETCH: assert rst after 2 returned words. Required: no fill_en, state back to IDLE, and the next miss fetches all 4 words starting from word 0.
